wb_uart_tx: RTL and testbench

Wishbone-fed UART transmitter: a Wishbone device that accepts one byte per write transaction and serialises it as an 8N1 frame on a single output line. It sits downstream of a byte FIFO's Wishbone controller port and drains it one byte per frame. Back-pressure is applied with `stall_o` while a frame is in flight.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_counter.sv | 28 ++
 rtl/wb_uart_tx.sv | 110 +++++++++++
 tb/tb_wb_uart_tx.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;
    localparam logic UART_START     = 1'b0;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: tick is combinational from the count; count clears on the cycle after clear.
// Backpressure: none, free-running between clears.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-fed 8N1 UART transmitter, one byte per accepted write.
// Latency: ack and start bit one cycle after accept; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: stall_o holds off new requests for the whole frame.
module wb_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [7:0] dat_i,
    output logic       ack_o,
    output logic       stall_o,
    output logic       tx_o
);

    uart_tx_state_t state, state_n;
    logic [7:0]     shreg, shreg_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic           tx_q, tx_n;
    logic           ack_q, stall_q;
    logic           accept, baud_tick;

    assign accept = cyc_i && stb_i && !stall_q;

    // Reads are accepted too, so clearing on any accept keeps the timer aligned for free.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (accept),
        .tick  (baud_tick)
    );

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        case (state)
            IDLE: begin
                if (accept && we_i) begin
                    state_n   = START;
                    shreg_n   = dat_i;
                    bit_cnt_n = 3'd0;
                end
            end
            START: begin
                if (baud_tick) state_n = DATA;
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                        state_n   = STOP;
                        bit_cnt_n = 3'd0;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level is registered from next-state so tx_o is glitch-free and aligned with stall_o.
    always_comb begin
        tx_n = UART_IDLE;
        case (state_n)
            START:   tx_n = UART_START;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
            tx_q    <= UART_IDLE;
            ack_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            tx_q    <= tx_n;
            ack_q   <= accept;
            stall_q <= (state_n != IDLE);
        end
    end

    assign ack_o   = ack_q;
    assign stall_o = stall_q;
    assign tx_o    = tx_q;

`ifdef FORMAL
    a_stall_state : assert property (@(posedge clk_i) stall_o == (state != IDLE));
    a_ack_single  : assert property (@(posedge clk_i) disable iff (rst_i) ack_o |=> !ack_o);
    a_idle_line   : assert property (@(posedge clk_i) (state == IDLE) |-> tx_o);
`endif

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx at CLKS_PER_BIT=4: reset, single/back-to-back frames, held requests, reads, mid-frame reset.
module tb_wb_uart_tx;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cyc_i = 1'b0;
    logic       stb_i = 1'b0;
    logic       we_i  = 1'b0;
    logic [7:0] dat_i = 8'h00;
    logic       ack_o, stall_o, tx_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wb_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cyc_i   (cyc_i),
        .stb_i   (stb_i),
        .we_i    (we_i),
        .dat_i   (dat_i),
        .ack_o   (ack_o),
        .stall_o (stall_o),
        .tx_o    (tx_o)
    );

    always #5 clk_i = ~clk_i;

    // After each step the bench sits 1 time unit into the next cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Entered in cycle N+1 of an accepted write; returns in cycle N+41.
    task automatic frame_check(input logic [7:0] b, input bit scramble, input string tag);
        logic [9:0] fr;
        logic [7:0] dec;
        fr  = {1'b1, b, 1'b0};
        dec = 8'h00;
        check({tag, " ack"}, ack_o, 1);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("%s tx c%0d", tag, i), tx_o, fr[i/4]);
            check($sformatf("%s stall c%0d", tag, i), stall_o, 1);
            if (i > 0) check($sformatf("%s noack c%0d", tag, i), ack_o, 0);
            if ((i % 4 == 2) && (i / 4 >= 1) && (i / 4 <= 8)) dec[i/4-1] = tx_o;
            if (scramble) begin
                dat_i = 8'($urandom);
                if (i == 39) begin
                    cyc_i = 1'b0;
                    stb_i = 1'b0;
                end
            end
            step();
        end
        check({tag, " decoded"}, dec, b);
        check({tag, " end stall"}, stall_o, 0);
        check({tag, " end tx"}, tx_o, 1);
        check({tag, " end ack"}, ack_o, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        repeat (3) step();
        check("rst tx", tx_o, 1);
        check("rst stall", stall_o, 0);
        check("rst ack", ack_o, 0);
        rst_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check($sformatf("idle c%0d", i), {tx_o, stall_o, ack_o}, 3'b100);
        end

        // Single write of 0xA5
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hA5;
        step();
        cyc_i = 1'b0; stb_i = 1'b0; dat_i = 8'h00;
        frame_check(8'hA5, 1'b0, "a5");

        // Back-to-back 0x00 then 0xFF with the request held through the stall
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h00;
        step();
        dat_i = 8'hFF;
        frame_check(8'h00, 1'b0, "b2b0");
        step();
        cyc_i = 1'b0; stb_i = 1'b0;
        frame_check(8'hFF, 1'b0, "b2b1");

        // Held write with dat_i scrambled while stalled
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h5A;
        step();
        frame_check(8'h5A, 1'b1, "hold");
        repeat (3) step();
        check("hold no extra ack", ack_o, 0);
        check("hold no extra frame", stall_o, 0);

        // Read in idle
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; dat_i = 8'h00;
        step();
        check("rd ack", ack_o, 1);
        check("rd tx", tx_o, 1);
        check("rd stall", stall_o, 0);
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        check("rd ack drop", ack_o, 0);
        check("rd stall after", stall_o, 0);
        check("rd tx after", tx_o, 1);

        // Reset during the third data bit of 0x3C, with a request arriving alongside reset
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h3C;
        step();
        check("3c ack", ack_o, 1);
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (12) step();
        check("3c bit2 stall", stall_o, 1);
        check("3c bit2 tx", tx_o, 1);
        rst_i = 1'b1;
        cyc_i = 1'b1; stb_i = 1'b1; dat_i = 8'hEE;
        step();
        check("mid rst tx", tx_o, 1);
        check("mid rst stall", stall_o, 0);
        check("mid rst ack", ack_o, 0);
        rst_i = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0;
        step();
        check("post rst ack", ack_o, 0);
        check("post rst stall", stall_o, 0);
        check("post rst tx", tx_o, 1);

        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h81;
        step();
        cyc_i = 1'b0; stb_i = 1'b0; dat_i = 8'h00;
        frame_check(8'h81, 1'b0, "r81");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
